// File: rtl/ascii_pkg.sv
// Shared definitions for the ASCII decimal parser and command tokenizer:
// parser states, character constants and character-class helpers.
package ascii_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_NINE  = 8'h39;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_ZERO) && (c <= CH_NINE);
  endfunction

  function automatic logic is_delim(input logic [7:0] c);
    return (c == CH_SPACE) || (c == CH_TAB) || (c == CH_LF) || (c == CH_CR);
  endfunction

endpackage

// File: rtl/ascii_char_class.sv
// Combinational character classifier: exactly one of digit/delim/minus/invalid
// is set for every byte; o_value is the digit's binary value (0 otherwise).
module ascii_char_class
  import ascii_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_digit,
  output logic       o_delim,
  output logic       o_minus,
  output logic       o_invalid,
  output logic [3:0] o_value
);

  always_comb begin
    o_digit   = is_digit(i_char);
    o_delim   = is_delim(i_char);
    o_minus   = (i_char == CH_MINUS);
    o_invalid = !(o_digit || o_delim || o_minus);
    // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value
    o_value   = o_digit ? i_char[3:0] : 4'd0;
  end

endmodule

// File: rtl/ascii_dec_parser.sv
// Streaming ASCII decimal parser: one saturated binary result per
// whitespace-delimited token, with optional leading '-' when SIGNED=1.
module ascii_dec_parser
  import ascii_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter bit SIGNED    = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BIN_WIDTH-1:0] out_value,
  output logic                 out_overflow,
  output logic                 out_error,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Four guard bits hold acc*10 + 9 for any acc up to the limit.
  localparam int              AW      = BIN_WIDTH + 4;
  localparam logic [AW-1:0]   ONE     = AW'(1);
  localparam logic [AW-1:0]   LIM_POS = SIGNED ? (ONE << (BIN_WIDTH - 1)) - ONE
                                               : (ONE << BIN_WIDTH) - ONE;
  localparam logic [AW-1:0]   LIM_NEG = ONE << (BIN_WIDTH - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_live;
  logic [BIN_WIDTH-1:0] r_acc;
  logic                 r_neg;
  logic                 r_ovf;
  logic                 r_err;
  logic                 r_seen;

  logic                 w_digit;
  logic                 w_delim;
  logic                 w_minus;
  logic                 w_invalid;
  logic [3:0]           w_dval;
  logic                 w_lead_minus;
  logic                 w_bad;
  logic                 w_accept;
  logic                 w_take;
  logic [AW-1:0]        w_base;
  logic [AW-1:0]        w_prod;
  logic [AW-1:0]        w_limit;
  logic                 w_over;
  logic [BIN_WIDTH-1:0] w_sat;

  ascii_char_class u_class (
    .i_char    (in_data),
    .o_digit   (w_digit),
    .o_delim   (w_delim),
    .o_minus   (w_minus),
    .o_invalid (w_invalid),
    .o_value   (w_dval)
  );

  assign w_lead_minus = SIGNED && w_minus && (r_state == IDLE);
  assign w_bad        = w_invalid || (w_minus && !w_lead_minus);
  assign w_accept     = in_valid && in_ready;
  assign w_take       = out_valid && out_ready && !clear;

  // The first digit enters with a zero base, so it passes the same limit check.
  assign w_base  = (r_state == DIGITS) ? {4'd0, r_acc} : '0;
  assign w_prod  = w_base * AW'(10) + AW'(w_dval);
  assign w_limit = r_neg ? LIM_NEG : LIM_POS;
  assign w_over  = w_prod > w_limit;
  assign w_sat   = w_over ? w_limit[BIN_WIDTH-1:0] : w_prod[BIN_WIDTH-1:0];

  // NOTE: clocked blocks use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_live  <= 1'b1;
    end
  end

  // NOTE: default assignment first, so no path through the case leaves a latch.
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept && !w_delim) w_next_state = w_bad ? DRAIN : DIGITS;
        DIGITS:  if (w_accept && !w_digit) w_next_state = w_delim ? DONE : DRAIN;
        DRAIN:   if (w_accept && w_delim)  w_next_state = DONE;
        DONE:    if (w_take)               w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc  <= '0;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
      r_seen <= 1'b0;
    end else if (clear || w_take) begin
      r_acc  <= '0;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
      r_seen <= 1'b0;
    end else if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (w_digit) begin
            r_acc  <= w_sat;
            r_ovf  <= w_over;
            r_seen <= 1'b1;
          end else if (w_bad) begin
            r_err <= 1'b1;
          end else if (w_lead_minus) begin
            r_neg <= 1'b1;
          end
        end
        DIGITS: begin
          if (w_digit) begin
            r_acc  <= w_sat;
            r_ovf  <= r_ovf || w_over;
            r_seen <= 1'b1;
          end else if (w_delim) begin
            // a token that was only '-' is malformed
            if (!r_seen) r_err <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready     = r_live && (r_state != DONE) && !clear;
    out_valid    = (r_state == DONE);
    out_error    = out_valid && r_err;
    out_overflow = out_valid && r_ovf && !r_err;
    out_value    = '0;
    if (out_valid && !r_err) out_value = r_neg ? -r_acc : r_acc;
  end

endmodule

// File: tb/tb_ascii_dec_parser.sv
// Bench for ascii_dec_parser: an unsigned and a signed 16-bit instance share one
// character stream; a token-level model predicts every result and handshake.
module tb_ascii_dec_parser;

  typedef struct {
    logic [15:0] v;
    logic        o;
    logic        e;
  } res_t;

  typedef struct {
    string       txt;
    logic [15:0] uv;
    logic        uo;
    logic        ue;
    logic [15:0] sv;
    logic        so;
    logic        se;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        u_in_ready, s_in_ready;
  logic [15:0] u_out_value, s_out_value;
  logic        u_ovf, s_ovf, u_err, s_err, u_out_valid, s_out_valid;

  int          total = 0;
  int          bad = 0;
  res_t        exp_u[$], exp_s[$], got_u[$], got_s[$];
  byte unsigned tok[$];
  logic        acc_flag = 1'b0;
  logic        rand_ordy = 1'b0;
  logic        cur_ordy = 1'b1;

  logic [7:0]  delims[4] = '{8'h20, 8'h09, 8'h0A, 8'h0D};
  string       bnd[7] = '{"65535", "65536", "32767", "32768", "-32768", "-32769", "0000065535"};
  string       badch = "a+/:x";

  ascii_dec_parser #(.BIN_WIDTH(16), .SIGNED(1'b0)) u_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(u_in_ready),
    .out_value(u_out_value), .out_overflow(u_ovf), .out_error(u_err),
    .out_valid(u_out_valid), .out_ready(out_ready)
  );

  ascii_dec_parser #(.BIN_WIDTH(16), .SIGNED(1'b1)) s_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
    .out_value(s_out_value), .out_overflow(s_ovf), .out_error(s_err),
    .out_valid(s_out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Token meaning straight from the rules: magnitude, sign, range, legality.
  function automatic res_t model_eval(input bit sgn);
    res_t   r;
    longint mag;
    longint lim;
    bit     neg;
    bit     err;
    int     ndig;
    int     start;
    mag = 0; neg = 0; err = 0; ndig = 0; start = 0;
    if (sgn && tok[0] == 8'h2D) begin
      neg = 1;
      start = 1;
    end
    for (int i = start; i < tok.size(); i++) begin
      if (tok[i] >= 8'h30 && tok[i] <= 8'h39) begin
        mag = mag * 10 + longint'(tok[i]) - 48;
        ndig++;
        if (mag > 1000000) mag = 1000000;
      end else begin
        err = 1;
      end
    end
    if (ndig == 0) err = 1;
    lim = neg ? 32768 : (sgn ? 32767 : 65535);
    r.v = '0;
    r.o = 1'b0;
    r.e = err;
    if (!err) begin
      if (mag > lim) begin
        r.o = 1'b1;
        mag = lim;
      end
      r.v = neg ? 16'(-mag) : 16'(mag);
    end
    return r;
  endfunction

  task automatic model_char(input logic [7:0] c);
    if (c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D) begin
      if (tok.size() != 0) begin
        exp_u.push_back(model_eval(1'b0));
        exp_s.push_back(model_eval(1'b1));
        tok.delete();
      end
    end else begin
      tok.push_back(c);
    end
  endtask

  function automatic logic rnd_ordy();
    return $urandom_range(0, 3) != 0;
  endfunction

  // One clock: sample at the falling edge, drive, then predict the next rising edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic ordy, input logic clr);
    res_t r;
    res_t g;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    #1;
    check("u_out_valid", u_out_valid, exp_u.size() != 0);
    check("s_out_valid", s_out_valid, exp_s.size() != 0);
    check("u_in_ready", u_in_ready, (exp_u.size() == 0) && !clr);
    check("s_in_ready", s_in_ready, (exp_s.size() == 0) && !clr);
    acc_flag = in_valid && u_in_ready && !clear;
    if (clr) begin
      tok.delete();
      exp_u.delete();
      exp_s.delete();
    end else begin
      if (ordy && exp_u.size() != 0) begin
        r = exp_u.pop_front();
        check("u_value", u_out_value, r.v);
        check("u_ovf", u_ovf, r.o);
        check("u_err", u_err, r.e);
        g.v = u_out_value; g.o = u_ovf; g.e = u_err;
        got_u.push_back(g);
      end
      if (ordy && exp_s.size() != 0) begin
        r = exp_s.pop_front();
        check("s_value", s_out_value, r.v);
        check("s_ovf", s_ovf, r.o);
        check("s_err", s_err, r.e);
        g.v = s_out_value; g.o = s_ovf; g.e = s_err;
        got_s.push_back(g);
      end
      if (acc_flag) model_char(d);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    for (int k = 0; k < 40; k++) begin
      cycle(1'b1, c, rand_ordy ? rnd_ordy() : cur_ordy, 1'b0);
      if (acc_flag) return;
    end
    total++;
    bad++;
    $display("FAIL send_timeout: char %0h not accepted in 40 cycles", c);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_u.size() != 0 || exp_s.size() != 0) && k < 60) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      k++;
    end
    total++;
    if (exp_u.size() != 0 || exp_s.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: pending u=%0d s=%0d", exp_u.size(), exp_s.size());
      exp_u.delete();
      exp_s.delete();
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_u_out_valid", u_out_valid, 0);
    check("rst_s_out_valid", s_out_valid, 0);
    check("rst_u_in_ready", u_in_ready, 0);
    check("rst_u_value", u_out_value, 0);
    check("rst_s_value", s_out_value, 0);
    check("rst_u_flags", {u_ovf, u_err}, 0);
    tok.delete();
    exp_u.delete();
    exp_s.delete();
    in_valid = 1'b0;
    clear    = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic rand_token();
    byte unsigned q[$];
    string        b;
    int           k;
    k = $urandom_range(0, 9);
    if (k < 6) begin
      if ($urandom_range(0, 3) == 0) q.push_back(8'h2D);
      repeat ($urandom_range(1, 6)) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
    end else if (k == 6) begin
      b = bnd[$urandom_range(0, 6)];
      for (int i = 0; i < b.len(); i++) q.push_back(b[i]);
    end else if (k == 7) begin
      repeat ($urandom_range(1, 3)) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
      q.push_back(badch[$urandom_range(0, 4)]);
      repeat ($urandom_range(0, 2)) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
    end else if (k == 8) begin
      q.push_back(8'h2D);
    end else begin
      repeat (3) q.push_back(8'h30);
      repeat ($urandom_range(1, 5)) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
    end
    repeat ($urandom_range(1, 2)) q.push_back(delims[$urandom_range(0, 3)]);
    for (int i = 0; i < q.size(); i++) begin
      if ($urandom_range(0, 3) == 0) cycle(1'b0, 8'($urandom), rnd_ordy(), 1'b0);
      if ($urandom_range(0, 59) == 0) cycle(1'b1, 8'h37, rnd_ordy(), 1'b1);
      send_char(q[i]);
    end
  endtask

  initial begin
    vec_t vecs[$];
    vecs.push_back(vec_t'{"  65535 ", 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b0});
    vecs.push_back(vec_t'{"70000\n",  16'hFFFF, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0});
    vecs.push_back(vec_t'{"7 ",       16'd7,    1'b0, 1'b0, 16'd7,    1'b0, 1'b0});
    vecs.push_back(vec_t'{"-32768 ",  16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"-32769 ",  16'h0000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0});
    vecs.push_back(vec_t'{"32768 ",   16'h8000, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b0});
    vecs.push_back(vec_t'{"12a4 ",    16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1});
    vecs.push_back(vec_t'{"- ",       16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1});
    vecs.push_back(vec_t'{"5\r",      16'd5,    1'b0, 1'b0, 16'd5,    1'b0, 1'b0});
    vecs.push_back(vec_t'{"00042\t",  16'd42,   1'b0, 1'b0, 16'd42,   1'b0, 1'b0});
    vecs.push_back(vec_t'{"0 ",       16'd0,    1'b0, 1'b0, 16'd0,    1'b0, 1'b0});
    vecs.push_back(vec_t'{"-0 ",      16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"-12 ",     16'h0000, 1'b0, 1'b1, 16'hFFF4, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"99999999 ",16'hFFFF, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0});
    vecs.push_back(vec_t'{"65536 ",   16'hFFFF, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0});

    // Reset state
    #12;
    check("init_u_out_valid", u_out_valid, 0);
    check("init_s_out_valid", s_out_valid, 0);
    check("init_u_in_ready", u_in_ready, 0);
    check("init_s_in_ready", s_in_ready, 0);
    check("init_u_value", u_out_value, 0);
    check("init_u_flags", {u_ovf, u_err}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single-token vectors with the result taken immediately
    cur_ordy = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      got_u.delete();
      got_s.delete();
      send_str(vecs[i].txt);
      drain();
      check($sformatf("v%0d_u_count", i), got_u.size(), 1);
      check($sformatf("v%0d_s_count", i), got_s.size(), 1);
      if (got_u.size() != 0) begin
        check($sformatf("v%0d_u_val", i), got_u[0].v, vecs[i].uv);
        check($sformatf("v%0d_u_ovf", i), got_u[0].o, vecs[i].uo);
        check($sformatf("v%0d_u_err", i), got_u[0].e, vecs[i].ue);
      end
      if (got_s.size() != 0) begin
        check($sformatf("v%0d_s_val", i), got_s[0].v, vecs[i].sv);
        check($sformatf("v%0d_s_ovf", i), got_s[0].o, vecs[i].so);
        check($sformatf("v%0d_s_err", i), got_s[0].e, vecs[i].se);
      end
    end

    // Latency and the one-cycle bubble per token
    got_u.delete();
    send_str("3 ");
    cycle(1'b1, 8'h34, 1'b1, 1'b0);
    check("lat_out_valid", u_out_valid, 1);
    check("lat_bubble", acc_flag, 0);
    cycle(1'b1, 8'h34, 1'b1, 1'b0);
    check("lat_resume", acc_flag, 1);
    send_char(8'h20);
    drain();
    check("lat_count", got_u.size(), 2);
    if (got_u.size() == 2) begin
      check("lat_first", got_u[0].v, 3);
      check("lat_second", got_u[1].v, 4);
    end

    // Back-pressure: result held, no character accepted while pending
    got_u.delete();
    cur_ordy = 1'b0;
    send_str("1 ");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'h32, 1'b0, 1'b0);
      check("bp_hold_value", u_out_value, 1);
      check("bp_no_accept", acc_flag, 0);
    end
    cur_ordy = 1'b1;
    send_str("2 3 ");
    drain();
    check("bp_count", got_u.size(), 3);
    if (got_u.size() == 3) begin
      check("bp_r0", got_u[0].v, 1);
      check("bp_r1", got_u[1].v, 2);
      check("bp_r2", got_u[2].v, 3);
    end

    // Clear mid-token drops the partial value
    got_u.delete();
    send_str("12");
    cycle(1'b1, 8'h33, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    send_str("9 ");
    drain();
    check("clr_count", got_u.size(), 1);
    if (got_u.size() != 0) check("clr_value", got_u[0].v, 9);

    // Asynchronous reset mid-token and with a result pending
    got_u.delete();
    send_str("83");
    async_reset();
    cur_ordy = 1'b0;
    send_str("45 ");
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_pending_valid", u_out_valid, 1);
    check("rst_pending_value", u_out_value, 45);
    async_reset();
    cur_ordy = 1'b1;
    send_str("6 ");
    drain();
    check("rst_count", got_u.size(), 1);
    if (got_u.size() != 0) check("rst_value", got_u[0].v, 6);

    // Random tokens, gaps, back-pressure and occasional clear
    rand_ordy = 1'b1;
    for (int t = 0; t < 250; t++) rand_token();
    rand_ordy = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascii_dec_parser.md
# ascii_dec_parser

Streaming ASCII decimal-integer parser: consumes raw 8-bit characters over a valid/ready handshake and emits one binary integer per whitespace-delimited token. Handles an optional leading '-' (signed mode), range overflow and malformed tokens. Sits between the UART receive path and the UCI command decoder, converting numeric fields such as `wtime 300000` and `depth 12`.

## Interface
- BIN_WIDTH, 16: result width in bits, 4 to 64.
- SIGNED, 0: 1 accepts a leading '-' and produces a two's-complement result; 0 treats '-' as an invalid character.

- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort: drop any partial token and go to IDLE; also drops a pending result.
- in_data  in  8  ASCII character.
- in_valid  in  1  in_data valid.
- in_ready  out  1  character accepted when in_valid & in_ready.
- out_value  out  BIN_WIDTH  parsed value, saturated on overflow.
- out_overflow  out  1  token exceeded the representable range.
- out_error  out  1  token contained an invalid character, or was a bare '-'.
- out_valid  out  1  result held until taken.
- out_ready  in  1  result taken when out_valid & out_ready.

## Operation
- Delimiters: 0x20, 0x09, 0x0A, 0x0D. Digits: 0x30-0x39. Everything else is invalid, except '-' as the first character when SIGNED=1.
- State IDLE: delimiters are consumed and ignored.
  - A digit loads acc = digit and goes to DIGITS.
  - A '-' with SIGNED=1 sets neg and goes to DIGITS with acc = 0 and ndig = 0.
  - Any other character sets err and goes to DRAIN.
- State DIGITS: acc_next = acc*10 + digit, computed in BIN_WIDTH+4 bits.
  - If acc_next exceeds the limit, set sticky ovf and hold acc at the limit.
  - Limit: unsigned 2^W-1; signed positive 2^(W-1)-1; signed negative 2^(W-1).
  - A delimiter goes to DONE.
  - An invalid character sets err and goes to DRAIN.
- State DRAIN: characters are consumed until a delimiter, then go to DONE.
- State DONE: out_valid=1 and in_ready=0.
  - out_value = neg ? -acc : acc. A '-' with no digits gives value 0 and err=1.
  - On out_ready, clear acc, neg, ovf and err, then go to IDLE.
- When err is set, out_value is 0. ovf and err are never reported together; err wins.
- Leading zeros are legal and do not cause overflow ("00042" gives 42).

## Timing
- Reset values: out_valid=0, out_value=0, out_overflow=0, out_error=0, in_ready=0 during reset. State goes to IDLE, and in_ready=1 from the first cycle after reset deasserts.
- in_ready = (state != DONE) & !clear. It is registered-state based and has no combinational path from out_ready.
- Latency: if the terminating delimiter is accepted at edge N, out_valid is high after edge N.
- If out_ready is high in the first valid cycle, the result is taken at edge N+1. in_ready is high again after N+1: one bubble cycle per token.
- out_value, out_overflow and out_error are stable while out_valid=1 and out_ready=0.
- clear has priority over all handshakes in the same cycle. A character presented with clear is not accepted.
- Reset asserted mid-token: outputs go to their reset values immediately (asynchronous). No partial result is ever emitted.
- No end-of-stream flush. A token with no trailing delimiter stays pending until a delimiter or clear arrives.

## Structure
- Package ascii_pkg:
  - state enum {IDLE, DIGITS, DRAIN, DONE};
  - ASCII constants for '0', '9', '-', space, tab, LF and CR;
  - functions is_digit and is_delim.
- Sub-module ascii_char_class: combinational classifier taking 8 bits and producing {digit, delim, minus, invalid} plus the 4-bit digit value. It is shared with the command tokenizer.
- The accumulator, saturation compare and negation live in the top module. The limit is a localparam derived from BIN_WIDTH and SIGNED.

## Test plan
- W=16, SIGNED=0, "  65535 " with out_ready=1 → one result: 65535, ovf=0, err=0. Leading spaces produce no output.
- W=16, SIGNED=0, "70000\n" → value 65535, ovf=1, err=0. The following token "7 " gives 7 with flags clear.
- W=16, SIGNED=1, "-32768 -32769 32768 " → results 0x8000 (ovf=0), 0x8000 (ovf=1), 0x7FFF (ovf=1).
- "12a4 " and "- " → both give value 0 and err=1. Characters after 'a' are drained. The next token "5\r" gives 5.
- Back-pressure on "1 2 3 " with out_ready low for 10 cycles:
  - in_ready stays low after the first delimiter and out_value holds 1;
  - release out_ready → results 1, 2, 3 in order;
  - no character is lost or duplicated.
- Abort and reset: assert clear in the middle of "123" → no output, and "9 " then gives 9. Assert reset_n=0 mid-token → out_valid drops at once and the partial result is never emitted.
